// File: rtl/nanocore_pkg.sv
// NanoCore_pkg: shared BTB entry / prediction types and table sizing.
package NanoCore_pkg;
    localparam int PC_W        = 16;
    localparam int BTB_ENTRIES = 16;

    typedef struct packed {
        logic            valid;
        logic            is_jarl;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] tgt;
    } btb_t;

    typedef struct packed {
        logic            jump;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] pc;
    } btb_ctl_t;

    typedef logic [$clog2(BTB_ENTRIES)-1:0] btb_idx_t;
endpackage

// File: rtl/nanocore_btb_prio_enc.sv
// nanocore_btb_prio_enc: multi-hot vector -> {any bit set, lowest set index}.
module nanocore_btb_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         vec_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);
    always_comb begin
        found_o = |vec_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = ($clog2(N))'(i);
    end
endmodule

// File: rtl/nanocore_btb.sv
// nanocore_btb: fully-associative branch target buffer with 1-cycle registered
// prediction, execute-side training, round-robin replacement and full flush.
module nanocore_btb
    import NanoCore_pkg::*;
#(
    parameter int BTB_ENTRIES = NanoCore_pkg::BTB_ENTRIES,
    parameter int PC_W        = NanoCore_pkg::PC_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_lookup_valid,
    input  logic [PC_W-1:0] i_lookup_pc,
    output logic            o_pred_valid,
    output btb_ctl_t        o_btb_ctl,
    output logic            o_pred_is_jalr,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic [PC_W-1:0] i_upd_tgt,
    input  logic            i_upd_taken,
    input  logic            i_upd_is_jalr,
    input  logic            i_flush
);
    localparam int IW = $clog2(BTB_ENTRIES);

    btb_t                   tbl_q [BTB_ENTRIES];
    btb_t                   tbl_d [BTB_ENTRIES];
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [BTB_ENTRIES-1:0] lk_match, up_match, free_vec;
    logic                   lk_found, free_found;
    logic [IW-1:0]          lk_idx, free_idx, wr_idx;
    btb_ctl_t               ctl_q;
    logic                   pred_valid_q, pred_jalr_q;

    always_comb begin
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            lk_match[i] = tbl_q[i].valid && tbl_q[i].pc == i_lookup_pc;
            up_match[i] = tbl_q[i].valid && tbl_q[i].pc == i_upd_pc;
            free_vec[i] = !tbl_q[i].valid;
        end
    end

    nanocore_btb_prio_enc #(.N(BTB_ENTRIES)) u_lk_enc (
        .vec_i(lk_match), .found_o(lk_found), .idx_o(lk_idx)
    );

    nanocore_btb_prio_enc #(.N(BTB_ENTRIES)) u_free_enc (
        .vec_i(free_vec), .found_o(free_found), .idx_o(free_idx)
    );

    assign wr_idx = free_found ? free_idx : ptr_q;

    // Update match is one-hot by construction, so entries are trained in place without an index.
    always_comb begin
        tbl_d = tbl_q;
        ptr_d = ptr_q;
        if (i_flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) tbl_d[i].valid = 1'b0;
            ptr_d = '0;
        end else if (i_upd_valid && |up_match) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                if (up_match[i] && i_upd_taken) begin
                    tbl_d[i].tgt     = i_upd_tgt;
                    tbl_d[i].is_jarl = i_upd_is_jalr;
                end else if (up_match[i]) begin
                    tbl_d[i].valid = 1'b0;
                end
            end
        end else if (i_upd_valid && i_upd_taken) begin
            tbl_d[wr_idx] = '{valid: 1'b1, is_jarl: i_upd_is_jalr, pc: i_upd_pc, tgt: i_upd_tgt};
            ptr_d = free_found ? ptr_q : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) tbl_q[i] <= '0;
            ptr_q        <= '0;
            ctl_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_jalr_q  <= 1'b0;
        end else begin
            tbl_q        <= tbl_d;
            ptr_q        <= ptr_d;
            pred_valid_q <= i_lookup_valid;
            ctl_q.pc     <= i_lookup_pc;
            ctl_q.jump   <= lk_found && i_lookup_valid;
            ctl_q.tgt    <= lk_found ? tbl_q[lk_idx].tgt : '0;
            pred_jalr_q  <= lk_found && tbl_q[lk_idx].is_jarl;
        end
    end

    assign o_pred_valid   = pred_valid_q;
    assign o_btb_ctl      = ctl_q;
    assign o_pred_is_jalr = pred_jalr_q;
endmodule
